sample_coef_buffer: RTL and testbench

Producer-side buffer that feeds the multiplier sequencer. It stages incoming samples (PushIn) in a circular FIFO and answers the sequencer's fifoPullOut pulls with registered head-of-queue data. It also holds the three-group coefficient bank loaded by PushCoef and drives the coefficient selected by the sequencer's multiplier_mux_sel. It sits between the input port and the multiply/accumulate datapath.

---
 rtl/sample_coef_buffer.sv | 109 ++++++++++
 tb/tb_sample_coef_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_coef_buffer.sv
// Sample FIFO with registered pull output and a three-entry coefficient bank
// feeding the multiplier sequencer; PushCoef also flushes queued samples.
module sample_coef_buffer #(
  parameter int DATA_W = 24,
  parameter int COEF_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PushIn,
  input  logic signed [DATA_W-1:0] DataIn,
  input  logic                     PushCoef,
  input  logic signed [COEF_W-1:0] CoefIn,
  input  logic                     fifoPullOut,
  input  logic [1:0]               multiplier_mux_sel,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [CNT_W-1:0]         fifo_count,
  output logic signed [DATA_W-1:0] DataOut,
  output logic                     data_valid,
  output logic signed [COEF_W-1:0] coef_out,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         occ;
  logic signed [COEF_W-1:0] coef0;
  logic signed [COEF_W-1:0] coef1;
  logic signed [COEF_W-1:0] coef2;
  logic [1:0]               coef_idx;
  logic signed [DATA_W-1:0] data_p1;
  logic                     vld_p1;
  logic                     ovf_q;
  logic                     unf_q;
  logic                     pull_ok;
  logic                     push_ok;
  logic                     push_drop;
  logic                     pull_rej;

  assign occ        = wr_ptr - rd_ptr;
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == CNT_W'(DEPTH));
  assign fifo_count = occ;

  // A coefficient load owns the cycle: any sample strobe alongside it is discarded silently.
  assign pull_ok   = fifoPullOut & ~PushCoef & ~fifo_empty;
  assign push_ok   = PushIn & ~PushCoef & (~fifo_full | pull_ok);
  assign push_drop = PushIn & ~PushCoef & fifo_full & ~pull_ok;
  assign pull_rej  = fifoPullOut & ~PushCoef & fifo_empty;

  // Stage p0 -> p1: pointer/coef state update and registered head-of-queue read
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      coef_idx <= '0;
      coef0    <= '0;
      coef1    <= '0;
      coef2    <= '0;
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      vld_p1 <= pull_ok;
      if (pull_ok) data_p1 <= mem[rd_ptr[AW-1:0]];
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (PushCoef)     rd_ptr <= wr_ptr;
      else if (pull_ok) rd_ptr <= rd_ptr + 1'b1;
      if (PushCoef) begin
        case (coef_idx)
          2'd0:    coef0 <= CoefIn;
          2'd1:    coef1 <= CoefIn;
          default: coef2 <= CoefIn;
        endcase
        coef_idx <= (coef_idx == 2'd2) ? 2'd0 : coef_idx + 2'd1;
      end
      if (push_drop) ovf_q <= 1'b1;
      if (pull_rej)  unf_q <= 1'b1;
    end
  end

  // Storage is not cleared on reset, but a write never lands in a reset cycle.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr[AW-1:0]] <= DataIn;
  end

  always_comb begin
    coef_out = '0;
    case (multiplier_mux_sel)
      2'd0:    coef_out = coef0;
      2'd1:    coef_out = coef1;
      2'd2:    coef_out = coef2;
      default: coef_out = '0;
    endcase
  end

  assign DataOut    = data_p1;
  assign data_valid = vld_p1;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_sample_coef_buffer.sv
// Self-checking bench for sample_coef_buffer: vector table, hand-written
// corner sequences, and a queue scoreboard for pulled samples.
module tb_sample_coef_buffer;

  localparam int DATA_W = 24;
  localparam int COEF_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              PushIn;
  logic [DATA_W-1:0] DataIn;
  logic              PushCoef;
  logic [COEF_W-1:0] CoefIn;
  logic              fifoPullOut;
  logic [1:0]        multiplier_mux_sel;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] DataOut;
  logic              data_valid;
  logic [COEF_W-1:0] coef_out;
  logic              overflow;
  logic              underflow;

  sample_coef_buffer #(.DATA_W(DATA_W), .COEF_W(COEF_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .PushIn(PushIn), .DataIn(DataIn),
    .PushCoef(PushCoef), .CoefIn(CoefIn), .fifoPullOut(fifoPullOut),
    .multiplier_mux_sel(multiplier_mux_sel), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_count(fifo_count), .DataOut(DataOut),
    .data_valid(data_valid), .coef_out(coef_out), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [DATA_W-1:0] sb[$];

  typedef struct {
    logic              push;
    logic [DATA_W-1:0] din;
    logic              pull;
    logic              has_exp;
    logic [DATA_W-1:0] exp_data;
    int                exp_count;
    logic              exp_empty;
    logic              exp_full;
    logic              exp_ovf;
    logic              exp_unf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic step(input logic p, input logic [DATA_W-1:0] d, input logic pl,
                      input logic pc, input logic [COEF_W-1:0] c);
    PushIn = p; DataIn = d; fifoPullOut = pl; PushCoef = pc; CoefIn = c;
    @(posedge clk); #1;
    PushIn = 1'b0; fifoPullOut = 1'b0; PushCoef = 1'b0;
    if (data_valid) begin
      if (sb.size() == 0) chk("data_valid_without_pull", 32'(data_valid), 32'd0);
      else chk("DataOut", 32'(DataOut), 32'(sb.pop_front()));
    end else if (sb.size() != 0) begin
      chk("data_valid", 32'(data_valid), 32'd1);
      void'(sb.pop_front());
    end
  endtask

  task automatic flags(input string tag, input int cnt, input logic emp,
                       input logic ful, input logic ov, input logic un);
    chk({tag, "_count"}, 32'(fifo_count), 32'(cnt));
    chk({tag, "_empty"}, 32'(fifo_empty), 32'(emp));
    chk({tag, "_full"}, 32'(fifo_full), 32'(ful));
    chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
    chk({tag, "_underflow"}, 32'(underflow), 32'(un));
  endtask

  task automatic do_reset();
    reset = 1'b1; PushIn = 1'b1; DataIn = 24'h5A5A5A; fifoPullOut = 1'b1;
    PushCoef = 1'b1; CoefIn = 16'h7777;
    @(posedge clk); #1;
    reset = 1'b0; PushIn = 1'b0; fifoPullOut = 1'b0; PushCoef = 1'b0;
    sb.delete();
  endtask

  task automatic check_reset_state(input string tag);
    flags(tag, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk({tag, "_DataOut"}, 32'(DataOut), 32'd0);
    chk({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_coef_out"}, 32'(coef_out), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; PushIn = 1'b0; DataIn = '0; PushCoef = 1'b0; CoefIn = '0;
    fifoPullOut = 1'b0; multiplier_mux_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state("reset");

    // Basic ordering, then push+pull throughput on a non-empty queue
    vecs[0] = '{1'b1, 24'h000011, 1'b0, 1'b0, 24'h0,      1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 24'h000022, 1'b0, 1'b0, 24'h0,      2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 24'h000033, 1'b0, 1'b0, 24'h0,      3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h000011, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h000022, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h000033, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 24'h000044, 1'b0, 1'b0, 24'h0,      1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 24'h000055, 1'b1, 1'b1, 24'h000044, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 24'h0,      1'b1, 1'b1, 24'h000055, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].has_exp) sb.push_back(vecs[i].exp_data);
      step(vecs[i].push, vecs[i].din, vecs[i].pull, 1'b0, '0);
      flags($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_empty,
            vecs[i].exp_full, vecs[i].exp_ovf, vecs[i].exp_unf);
    end

    // Fill, overflow, drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 24'h000100 + 24'(i), 1'b0, 1'b0, '0);
    flags("filled", 8, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 24'hABCDEF, 1'b0, 1'b0, '0);
    flags("ovf", 8, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(24'h000100 + 24'(i));
      step(1'b0, '0, 1'b1, 1'b0, '0);
    end
    flags("ovf_drained", 0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Full with simultaneous push and pull
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 24'h000200 + 24'(i), 1'b0, 1'b0, '0);
    sb.push_back(24'h000200);
    step(1'b1, 24'h000099, 1'b1, 1'b0, '0);
    flags("full_pp", 8, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      sb.push_back(24'h000200 + 24'(i));
      step(1'b0, '0, 1'b1, 1'b0, '0);
    end
    sb.push_back(24'h000099);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    flags("full_pp_drained", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Pull while empty with a same-cycle push: no bypass
    do_reset();
    step(1'b1, 24'h000005, 1'b1, 1'b0, '0);
    flags("unf", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(24'h000005);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    flags("unf_after", 0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Coefficient loads flush the queue and swallow same-cycle strobes
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 24'h000300 + 24'(i), 1'b0, 1'b0, '0);
    flags("pre_coef", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 24'h000077, 1'b1, 1'b1, 16'h0100);
    flags("coef_flush", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 16'h0200);
    step(1'b0, '0, 1'b0, 1'b1, 16'h0300);
    step(1'b0, '0, 1'b0, 1'b1, 16'h0400);
    begin
      logic [COEF_W-1:0] exp_coef [4];
      exp_coef = '{16'h0400, 16'h0200, 16'h0300, 16'h0000};
      for (int s = 0; s < 4; s++) begin
        multiplier_mux_sel = 2'(s);
        #1;
        chk($sformatf("coef_sel%0d", s), 32'(coef_out), 32'(exp_coef[s]));
      end
    end
    flags("coef_done", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation: 5 queued, overflow set, coefficient loaded
    do_reset();
    multiplier_mux_sel = 2'd0;
    step(1'b0, '0, 1'b0, 1'b1, 16'h0AAA);
    chk("mid_coef", 32'(coef_out), 32'h0AAA);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 24'h000400 + 24'(i), 1'b0, 1'b0, '0);
    step(1'b1, 24'hABCDEF, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(24'h000400 + 24'(i));
      step(1'b0, '0, 1'b1, 1'b0, '0);
    end
    flags("pre_reset", 5, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    check_reset_state("mid_reset");
    step(1'b0, '0, 1'b0, 1'b0, '0);
    flags("post_reset_idle", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
